// File: rtl/deser_feed_arbiter_if.sv
// Handshake and serial-link bundle between two byte requesters, the feed
// arbiter and a bit-serial deserializer.
interface deser_feed_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       des_status;
    logic       ser_data;
    logic       ser_write;
    logic       busy;

    modport master (
        input  req0, req1, data0, data1, des_status,
        output gnt0, gnt1, done0, done1, ser_data, ser_write, busy
    );

    modport slave (
        output req0, req1, data0, data1, des_status,
        input  gnt0, gnt1, done0, done1, ser_data, ser_write, busy
    );
endinterface

// File: rtl/deser_feed_arbiter.sv
// Arbitrates two byte requesters and feeds the winner's byte MSB first into a
// deserializer. Define ROUND_ROBIN_EN for round-robin arbitration (default: req0 priority).
module deser_feed_arbiter #(
    parameter int unsigned GAP_CYCLES = 32'd1
) (
    input  logic                  clk_100KHz,
    input  logic                  reset,
    deser_feed_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 32'd0) ? 4'(GAP_CYCLES - 32'd1) : 4'd0;

    state_t     state_r;
    state_t     state_next;
    logic [7:0] shreg_r;
    logic [7:0] shreg_next;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_next;
    logic [3:0] gap_cnt_r;
    logic [3:0] gap_cnt_next;
    logic       owner_r;
    logic       owner_next;
    logic       grant_s;
    logic       win1_s;

    logic       gnt0_r;
    logic       gnt1_r;
    logic       done0_r;
    logic       done1_r;
    logic       ser_data_r;
    logic       ser_write_r;
    logic       busy_r;

`ifdef ROUND_ROBIN_EN
    logic       prio1_r;

    assign win1_s = bus.req1 & (~bus.req0 | prio1_r);

    // Pointer favours the requester that did not win the latest grant
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            prio1_r <= 1'b0;
        end else if (grant_s) begin
            prio1_r <= ~win1_s;
        end else begin
            prio1_r <= prio1_r;
        end
    end
`else
    assign win1_s = bus.req1 & ~bus.req0;
`endif

    // State register
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and datapath update; requests are only looked at in IDLE
    always_comb begin
        state_next   = state_r;
        shreg_next   = shreg_r;
        bit_cnt_next = bit_cnt_r;
        gap_cnt_next = gap_cnt_r;
        owner_next   = owner_r;
        grant_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.des_status && (bus.req0 || bus.req1)) begin
                    grant_s      = 1'b1;
                    owner_next   = win1_s;
                    shreg_next   = win1_s ? bus.data1 : bus.data0;
                    bit_cnt_next = 3'd0;
                    gap_cnt_next = 4'd0;
                    state_next   = SHIFT;
                end else begin
                    state_next   = IDLE;
                end
            end
            SHIFT: begin
                shreg_next   = {shreg_r[6:0], 1'b0};
                bit_cnt_next = bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    state_next = DONE;
                end else if (GAP_CYCLES > 32'd0) begin
                    state_next   = GAP;
                    gap_cnt_next = 4'd0;
                end else begin
                    state_next = SHIFT;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next   = SHIFT;
                    gap_cnt_next = 4'd0;
                end else begin
                    gap_cnt_next = gap_cnt_r + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            shreg_r     <= 8'd0;
            bit_cnt_r   <= 3'd0;
            gap_cnt_r   <= 4'd0;
            owner_r     <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            ser_data_r  <= 1'b0;
            ser_write_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            shreg_r     <= shreg_next;
            bit_cnt_r   <= bit_cnt_next;
            gap_cnt_r   <= gap_cnt_next;
            owner_r     <= owner_next;
            gnt0_r      <= grant_s & ~win1_s;
            gnt1_r      <= grant_s & win1_s;
            done0_r     <= (state_next == DONE) & ~owner_next;
            done1_r     <= (state_next == DONE) & owner_next;
            ser_write_r <= (state_next == SHIFT);
            ser_data_r  <= (state_next == SHIFT) & shreg_next[7];
            busy_r      <= (state_next != IDLE);
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.done0     = done0_r;
    assign bus.done1     = done1_r;
    assign bus.ser_data  = ser_data_r;
    assign bus.ser_write = ser_write_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_deser_feed_arbiter.sv
// Self-checking bench: two instances (gap 1 and gap 0) compared cycle by cycle
// against a timeline model of each transfer, plus a behavioural deserializer.
module tb_deser_feed_arbiter;

    logic clk_100KHz = 1'b0;
    always #5 clk_100KHz = ~clk_100KHz;

    logic       reset;
    logic       r0a, r1a, st_a, r0b;
    logic [7:0] d0a, d1a, d0b;
    logic       deser_en, ack;
    logic [7:0] des_sh, des_out;
    logic [2:0] des_cnt;
    logic       des_full;
    int         checks = 0;
    int         errors = 0;
    bit         prio1_m;

    deser_feed_arbiter_if ifa ();
    deser_feed_arbiter_if ifb ();

    assign ifa.req0       = r0a;
    assign ifa.req1       = r1a;
    assign ifa.data0      = d0a;
    assign ifa.data1      = d1a;
    assign ifa.des_status = deser_en ? des_full : st_a;
    assign ifb.req0       = r0b;
    assign ifb.req1       = 1'b0;
    assign ifb.data0      = d0b;
    assign ifb.data1      = 8'd0;
    assign ifb.des_status = 1'b0;

    deser_feed_arbiter #(.GAP_CYCLES(1)) dut_a (.clk_100KHz(clk_100KHz), .reset(reset), .bus(ifa));
    deser_feed_arbiter #(.GAP_CYCLES(0)) dut_b (.clk_100KHz(clk_100KHz), .reset(reset), .bus(ifb));

    logic [6:0] obs_a, obs_b;
    assign obs_a = {ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.ser_write, ifa.ser_data, ifa.busy};
    assign obs_b = {ifb.gnt0, ifb.gnt1, ifb.done0, ifb.done1, ifb.ser_write, ifb.ser_data, ifb.busy};

    // Behavioural deserializer: collects 8 written bits, holds status until acked
    always @(posedge clk_100KHz) begin
        if (reset) begin
            des_sh   <= 8'd0;
            des_cnt  <= 3'd0;
            des_full <= 1'b0;
            des_out  <= 8'd0;
        end else begin
            if (deser_en && ifa.ser_write) begin
                des_sh  <= {des_sh[6:0], ifa.ser_data};
                des_cnt <= des_cnt + 3'd1;
                if (des_cnt == 3'd7) begin
                    des_full <= 1'b1;
                    des_out  <= {des_sh[6:0], ifa.ser_data};
                end
            end
            if (ack) des_full <= 1'b0;
        end
    end

    function automatic int pick(input logic r0, input logic r1);
`ifdef ROUND_ROBIN_EN
        return (r1 && (!r0 || prio1_m)) ? 1 : 0;
`else
        return (r1 && !r0) ? 1 : 0;
`endif
    endfunction

    task automatic set_req(input int gap, input logic r0, input logic r1);
        if (gap == 0) begin
            r0b = r0;
        end else begin
            r0a = r0;
            r1a = r1;
        end
    endtask

    task automatic do_reset();
        r0a = 1'b0; r1a = 1'b0; r0b = 1'b0;
        reset = 1'b1;
        @(posedge clk_100KHz); #1;
        reset   = 1'b0;
        prio1_m = 1'b0;
    endtask

    // Called with the request already driven in an IDLE cycle N; checks N+1 .. idle
    task automatic check_transfer(input int gap, input int win, input logic [7:0] dat,
                                  input bit perturb, input logic e0, input logic e1);
        int p, last, k;
        logic wr;
        logic [6:0] exp, got;
        p    = gap + 1;
        last = 7 * p + 3;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk_100KHz); #1;
            k   = (c - 1) / p;
            wr  = ((c - 1) % p == 0) && (k < 8);
            exp = 7'd0;
            exp[6] = (c == 1) && (win == 0);
            exp[5] = (c == 1) && (win == 1);
            exp[4] = (c == 7 * p + 2) && (win == 0);
            exp[3] = (c == 7 * p + 2) && (win == 1);
            exp[2] = wr;
            if (wr) exp[1] = dat[7 - k];
            exp[0] = (c <= 7 * p + 2);
            got = (gap == 0) ? obs_b : obs_a;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL transfer gap=%0d cycle=%0d {gnt0,gnt1,done0,done1,wr,data,busy} got %b expected %b",
                         gap, c, got, exp);
            end
            if (perturb && c < last - 1) begin
                r0a = 1'($urandom_range(1, 0));
                r1a = 1'($urandom_range(1, 0));
                d0a = 8'($urandom);
                d1a = 8'($urandom);
            end
            if (c == last - 1) set_req(gap, e0, e1);
        end
    endtask

    task automatic check_quiet(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_100KHz); #1;
            checks++;
            if (obs_a !== 7'd0) begin
                errors++;
                $display("FAIL %s cycle=%0d outputs got %b expected 0000000", name, c, obs_a);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk_100KHz); #1;
        @(posedge clk_100KHz); #1;
        checks++;
        if ({obs_a, obs_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got %b expected all zero", {obs_a, obs_b});
        end
        reset   = 1'b0;
        prio1_m = 1'b0;
        check_quiet("post_reset_idle", 2);
    endtask

    task automatic test_basic();
        int win;
        d0a = 8'hAD;
        set_req(1, 1'b1, 1'b0);
        win = pick(1'b1, 1'b0);
        prio1_m = (win == 0);
        check_transfer(1, win, 8'hAD, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_status();
        int win;
        logic [7:0] dat;
        dat  = 8'($urandom);
        d1a  = dat;
        st_a = 1'b1;
        set_req(1, 1'b0, 1'b1);
        check_quiet("status_hold", 19);
        st_a = 1'b0;
        win = pick(1'b0, 1'b1);
        prio1_m = (win == 0);
        check_transfer(1, win, dat, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int win;
        do_reset();
        d0a = 8'h3C;
        d1a = 8'hC3;
        set_req(1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            win = pick(1'b1, 1'b1);
            prio1_m = (win == 0);
            check_transfer(1, win, (win == 1) ? 8'hC3 : 8'h3C, 1'b0, (i < 2), (i < 2));
        end
    endtask

    task automatic test_gap0();
        d0b = 8'hFF;
        set_req(0, 1'b1, 1'b0);
        check_transfer(0, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        d0b = 8'h96;
        set_req(0, 1'b1, 1'b0);
        check_transfer(0, 0, 8'h96, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        d0a = 8'($urandom);
        set_req(1, 1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk_100KHz); #1;
        end
        checks++;
        if (obs_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fourth_write ser_write got %b expected 1", obs_a[2]);
        end
        reset = 1'b1;
        r0a   = 1'b0;
        @(posedge clk_100KHz); #1;
        checks++;
        if (obs_a !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_abort outputs got %b expected 0000000", obs_a);
        end
        reset   = 1'b0;
        prio1_m = 1'b0;
        check_quiet("reset_mid_no_done", 12);
        d0a = 8'h01;
        set_req(1, 1'b1, 1'b0);
        prio1_m = (pick(1'b1, 1'b0) == 0);
        check_transfer(1, 0, 8'h01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_deser();
        int win;
        logic [7:0] dat;
        do_reset();
        deser_en = 1'b1;
        d0a = 8'hAD;
        set_req(1, 1'b1, 1'b0);
        prio1_m = (pick(1'b1, 1'b0) == 0);
        check_transfer(1, 0, 8'hAD, 1'b0, 1'b0, 1'b0);
        checks++;
        if (des_full !== 1'b1 || des_out !== 8'hAD) begin
            errors++;
            $display("FAIL deser_receive ready/data got %b/%h expected 1/ad", des_full, des_out);
        end
        dat = 8'($urandom);
        d1a = dat;
        set_req(1, 1'b0, 1'b1);
        check_quiet("deser_blocked", 4);
        ack = 1'b1;
        check_quiet("deser_ack_edge", 1);
        ack = 1'b0;
        win = pick(1'b0, 1'b1);
        prio1_m = (win == 0);
        check_transfer(1, win, dat, 1'b0, 1'b0, 1'b0);
        checks++;
        if (des_out !== dat) begin
            errors++;
            $display("FAIL deser_second_byte data got %h expected %h", des_out, dat);
        end
        deser_en = 1'b0;
    endtask

    task automatic test_random();
        int win;
        logic r0, r1;
        logic [7:0] x0, x1;
        for (int i = 0; i < 20; i++) begin
            r0 = 1'($urandom_range(1, 0));
            r1 = 1'($urandom_range(1, 0));
            if (!r0 && !r1) r0 = 1'b1;
            x0 = 8'($urandom);
            x1 = 8'($urandom);
            d0a = x0;
            d1a = x1;
            set_req(1, r0, r1);
            win = pick(r0, r1);
            prio1_m = (win == 0);
            check_transfer(1, win, (win == 1) ? x1 : x0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        r0a = 1'b0; r1a = 1'b0; st_a = 1'b0; r0b = 1'b0;
        d0a = 8'd0; d1a = 8'd0; d0b = 8'd0;
        deser_en = 1'b0; ack = 1'b0; prio1_m = 1'b0;
        test_reset();
        test_basic();
        test_status();
        test_back_to_back();
        test_gap0();
        test_reset_mid();
        test_deser();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
